// File: rtl/vec_alu_pkg.sv
// Shared constants, opcode map and sequencer state type for the vector ALU slice.
package vec_alu_pkg;

  localparam int ELEMENT_SIZE_DEF = 16;
  localparam int NUM_ELEMENTS_DEF = 8;
  localparam int LANES_DEF        = 2;
  localparam int OPCODE_W         = 3;

  // Element opcodes understood by alu_element_vec; every lane receives the same code.
  localparam logic [OPCODE_W-1:0] OP_ADD  = 3'b000;  // a + b, wrapping
  localparam logic [OPCODE_W-1:0] OP_SUB  = 3'b001;  // a - b, wrapping
  localparam logic [OPCODE_W-1:0] OP_AND  = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_OR   = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_XOR  = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_SLL  = 3'b101;  // a << b[log2(ELEMENT_SIZE)-1:0]
  localparam logic [OPCODE_W-1:0] OP_SRL  = 3'b110;  // a >> b[log2(ELEMENT_SIZE)-1:0]
  localparam logic [OPCODE_W-1:0] OP_MOVA = 3'b111;  // pass a through

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/vec_alu_sequencer_alu.sv
// Single-element combinational ALU; results wrap modulo 2^ELEMENT_SIZE, no flags.
module alu_element_vec
  import vec_alu_pkg::*;
#(
  parameter int ELEMENT_SIZE = ELEMENT_SIZE_DEF
) (
  input  logic [OPCODE_W-1:0]     i_opcode,
  input  logic [ELEMENT_SIZE-1:0] i_a,
  input  logic [ELEMENT_SIZE-1:0] i_b,
  output logic [ELEMENT_SIZE-1:0] o_result
);

  localparam int SH_W = (ELEMENT_SIZE > 1) ? $clog2(ELEMENT_SIZE) : 1;

  logic [SH_W-1:0] w_shamt;

  // Shifts only look at the low bits of b so the amount always stays inside the element.
  assign w_shamt = i_b[SH_W-1:0];

  // Opcode decode; unlisted codes fall back to passing a.
  always_comb begin
    o_result = i_a;
    case (i_opcode)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_SLL:  o_result = i_a << w_shamt;
      OP_SRL:  o_result = i_a >> w_shamt;
      default: o_result = i_a;
    endcase
  end

endmodule

// File: rtl/vec_alu_sequencer.sv
// Vector execute stage: latches one operation, streams LANES element pairs per cycle
// through alu_element_vec lanes, and holds the assembled result on a valid/ready port.
module vec_alu_sequencer
  import vec_alu_pkg::*;
#(
  parameter int ELEMENT_SIZE = ELEMENT_SIZE_DEF,
  parameter int NUM_ELEMENTS = NUM_ELEMENTS_DEF,
  parameter int LANES        = LANES_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [OPCODE_W-1:0]              in_opcode,
  input  logic [NUM_ELEMENTS*ELEMENT_SIZE-1:0] in_vec_a,
  input  logic [NUM_ELEMENTS*ELEMENT_SIZE-1:0] in_vec_b,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_ELEMENTS*ELEMENT_SIZE-1:0] out_vec,
  output logic                             busy
);

  localparam int IDX_W = (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS - LANES);
  localparam logic [IDX_W-1:0] STEP     = IDX_W'(LANES);

  // Lanes must tile the vector exactly, otherwise the last beat would straddle the end.
  if ((LANES < 1) || ((NUM_ELEMENTS % LANES) != 0)) begin : g_bad_lanes
    $error("vec_alu_sequencer: NUM_ELEMENTS must be a non-zero multiple of LANES");
  end

  seq_state_t r_state;
  seq_state_t w_next_state;

  logic [IDX_W-1:0]        r_idx;
  logic [OPCODE_W-1:0]     r_opcode;
  logic [ELEMENT_SIZE-1:0] r_vec_a [NUM_ELEMENTS];
  logic [ELEMENT_SIZE-1:0] r_vec_b [NUM_ELEMENTS];
  logic [ELEMENT_SIZE-1:0] r_result [NUM_ELEMENTS];

  logic                    w_accept;
  logic                    w_exec;
  logic                    w_last_beat;
  logic [IDX_W-1:0]        w_lane_idx [LANES];
  logic [ELEMENT_SIZE-1:0] w_lane_a   [LANES];
  logic [ELEMENT_SIZE-1:0] w_lane_b   [LANES];
  logic [ELEMENT_SIZE-1:0] w_lane_res [LANES];

  assign w_accept    = in_valid && in_ready;
  assign w_exec      = (r_state == EXEC);
  assign w_last_beat = (r_idx == LAST_IDX);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state and handshake outputs; in_ready is held low while reset is asserted.
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) w_next_state = EXEC;
      end
      EXEC: begin
        busy = 1'b1;
        if (w_last_beat) w_next_state = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Operand capture at accept; later changes on the input buses are ignored.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_opcode <= in_opcode;
      for (int i = 0; i < NUM_ELEMENTS; i++) begin
        r_vec_a[i] <= in_vec_a[i*ELEMENT_SIZE +: ELEMENT_SIZE];
        r_vec_b[i] <= in_vec_b[i*ELEMENT_SIZE +: ELEMENT_SIZE];
      end
    end
  end

  // Element index and result assembly; cleared at accept so no stale elements survive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx <= '0;
      for (int i = 0; i < NUM_ELEMENTS; i++) r_result[i] <= '0;
    end else if (w_accept) begin
      r_idx <= '0;
      for (int i = 0; i < NUM_ELEMENTS; i++) r_result[i] <= '0;
    end else if (w_exec) begin
      r_idx <= r_idx + STEP;
      for (int l = 0; l < LANES; l++) r_result[w_lane_idx[l]] <= w_lane_res[l];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign w_lane_idx[l] = r_idx + IDX_W'(l);
    assign w_lane_a[l]   = r_vec_a[w_lane_idx[l]];
    assign w_lane_b[l]   = r_vec_b[w_lane_idx[l]];

    alu_element_vec #(
      .ELEMENT_SIZE (ELEMENT_SIZE)
    ) u_alu (
      .i_opcode (r_opcode),
      .i_a      (w_lane_a[l]),
      .i_b      (w_lane_b[l]),
      .o_result (w_lane_res[l])
    );
  end

  for (genvar i = 0; i < NUM_ELEMENTS; i++) begin : g_pack
    assign out_vec[i*ELEMENT_SIZE +: ELEMENT_SIZE] = r_result[i];
  end

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Self-checking bench for vec_alu_sequencer with default parameters (8 x 16-bit, 2 lanes).
module tb_vec_alu_sequencer;

  localparam int ES = 16;
  localparam int NE = 8;
  localparam int VW = NE * ES;
  localparam int LATENCY = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_opcode;
  logic [VW-1:0] in_vec_a;
  logic [VW-1:0] in_vec_b;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_vec;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  vec_alu_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_opcode (in_opcode),
    .in_vec_a  (in_vec_a),
    .in_vec_b  (in_vec_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string         nm;
    logic [2:0]    op;
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    logic [VW-1:0] exp;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference: per-element integer arithmetic reduced modulo 2^16.
  function automatic logic [VW-1:0] model(input logic [2:0] op, input logic [VW-1:0] a,
                                          input logic [VW-1:0] b);
    logic [VW-1:0] r;
    longint x, y, z, sh;
    r = '0;
    for (int i = 0; i < NE; i++) begin
      x  = longint'(a[i*ES +: ES]);
      y  = longint'(b[i*ES +: ES]);
      sh = longint'(1) << (y % 16);
      case (op)
        3'd0:    z = (x + y) % 65536;
        3'd1:    z = (x - y + 65536) % 65536;
        3'd2:    z = x & y;
        3'd3:    z = x | y;
        3'd4:    z = x ^ y;
        3'd5:    z = (x * sh) % 65536;
        3'd6:    z = x / sh;
        default: z = x;
      endcase
      r[i*ES +: ES] = 16'(z);
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < NE; i++) r[i*ES +: ES] = 16'($urandom);
    return r;
  endfunction

  // Issue one operation from a negedge, follow it through EXEC and DONE, and hand it off.
  task automatic run_op(input string nm, input logic [2:0] op, input logic [VW-1:0] a,
                        input logic [VW-1:0] b, input logic [VW-1:0] exp,
                        input bit early_ready, input bit scramble);
    int n;
    bit busy_ok;
    chk({nm, " in_ready_idle"}, VW'(in_ready), VW'(1));
    in_opcode = op;
    in_vec_a  = a;
    in_vec_b  = b;
    in_valid  = 1'b1;
    out_ready = early_ready;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    busy_ok = 1'b1;
    while (!out_valid && n < 50) begin
      if (scramble) begin
        in_vec_a  = rand_vec();
        in_vec_b  = rand_vec();
        in_opcode = 3'($urandom);
      end
      if (!busy || in_ready) busy_ok = 1'b0;
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({nm, " latency"}, VW'(n), VW'(LATENCY));
    chk({nm, " busy_exec"}, VW'(busy_ok), VW'(1));
    chk({nm, " busy_done"}, VW'(busy), VW'(1));
    chk({nm, " out_vec"}, out_vec, exp);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " valid_drop"}, VW'(out_valid), VW'(0));
    chk({nm, " in_ready_back"}, VW'(in_ready), VW'(1));
    chk({nm, " out_vec_kept"}, out_vec, exp);
  endtask

  initial begin
    logic [VW-1:0] a1, b1, e1, a2, b2, e2, ra, rb;
    logic [2:0] rop;
    int n;

    tbl[0] = '{"add_basic", 3'd0,
               {16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd8},
               {8{16'd5}},
               {16'd12, 16'd11, 16'd10, 16'd9, 16'd8, 16'd7, 16'd6, 16'd13}};
    tbl[1] = '{"add_wrap_all", 3'd0, {8{16'hFFFF}}, {8{16'h0001}}, {8{16'h0000}}};
    tbl[2] = '{"add_wrap_e3", 3'd0,
               {{4{16'h0001}}, 16'h8000, {3{16'h0001}}},
               {{4{16'h0002}}, 16'h8000, {3{16'h0002}}},
               {{4{16'h0003}}, 16'h0000, {3{16'h0003}}}};
    tbl[3] = '{"sub_wrap", 3'd1, {8{16'h0000}}, {8{16'h0001}}, {8{16'hFFFF}}};
    tbl[4] = '{"and", 3'd2, {8{16'hF0F0}}, {8{16'hFF00}}, {8{16'hF000}}};
    tbl[5] = '{"or", 3'd3, {8{16'h1200}}, {8{16'h0034}}, {8{16'h1234}}};
    tbl[6] = '{"xor", 3'd4, {8{16'hAAAA}}, {8{16'hFFFF}}, {8{16'h5555}}};
    tbl[7] = '{"sll", 3'd5, {8{16'h0001}}, {8{16'h0013}}, {8{16'h0008}}};
    tbl[8] = '{"srl", 3'd6, {8{16'h8000}}, {8{16'h000F}}, {8{16'h0001}}};
    tbl[9] = '{"mova", 3'd7, {8{16'h1234}}, {8{16'h5678}}, {8{16'h1234}}};

    // Reset
    rst = 1'b1;
    in_valid = 1'b0;
    in_opcode = '0;
    in_vec_a = '0;
    in_vec_b = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready_held", VW'(in_ready), VW'(0));
    rst = 1'b0;
    #1;
    chk("rst_in_ready", VW'(in_ready), VW'(1));
    chk("rst_out_valid", VW'(out_valid), VW'(0));
    chk("rst_out_vec", out_vec, '0);
    chk("rst_busy", VW'(busy), VW'(0));
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 10; i++)
      run_op(tbl[i].nm, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp, 1'b0, 1'b0);

    // Backpressure with a second request arriving while DONE is held
    a1 = tbl[0].a; b1 = tbl[0].b; e1 = tbl[0].exp;
    a2 = {16'd100, 16'd90, 16'd80, 16'd70, 16'd60, 16'd50, 16'd40, 16'd30};
    b2 = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    e2 = {16'd99, 16'd88, 16'd77, 16'd66, 16'd55, 16'd44, 16'd33, 16'd22};
    in_opcode = 3'd0; in_vec_a = a1; in_vec_b = b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); n++; @(negedge clk);
    end
    chk("bp latency", VW'(n), VW'(LATENCY));
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        in_opcode = 3'd1; in_vec_a = a2; in_vec_b = b2; in_valid = 1'b1;
      end
      if (c == 5) in_valid = 1'b0;
      chk("bp out_valid_held", VW'(out_valid), VW'(1));
      chk("bp out_vec_stable", out_vec, e1);
      chk("bp in_ready_low", VW'(in_ready), VW'(0));
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp in_ready_after", VW'(in_ready), VW'(1));
    chk("bp out_valid_after", VW'(out_valid), VW'(0));
    chk("bp out_vec_not_overwritten", out_vec, e1);
    chk("bp model_self_e2", model(3'd1, a2, b2), e2);
    run_op("bp resend", 3'd1, a2, b2, e2, 1'b0, 1'b0);

    // Reset after two EXEC beats
    in_opcode = 3'd4; in_vec_a = {8{16'h0F0F}}; in_vec_b = {8{16'hFFFF}}; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort out_valid", VW'(out_valid), VW'(0));
    chk("abort out_vec", out_vec, '0);
    chk("abort busy", VW'(busy), VW'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort in_ready", VW'(in_ready), VW'(1));
    @(negedge clk);
    run_op("after_abort", 3'd0, {8{16'h0100}}, {8{16'h0023}}, {8{16'h0123}}, 1'b0, 1'b0);

    // Operands and opcode scrambled during EXEC
    run_op("stable_ops", tbl[0].op, tbl[0].a, tbl[0].b, tbl[0].exp, 1'b0, 1'b1);

    // Randomized operations against the reference model
    for (int k = 0; k < 24; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = rand_vec();
      rb  = rand_vec();
      run_op($sformatf("rand%0d", k), rop, ra, rb, model(rop, ra, rb),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vec_alu_sequencer.md
Name: vec_alu_sequencer

Overview:
Vector execute stage that sits directly upstream of alu_element_vec and also consumes its output. It accepts one vector ALU operation at a time: an opcode and two packed operand vectors of NUM_ELEMENTS elements each. It issues LANES element pairs per cycle to LANES alu_element_vec instances and assembles their outputs into a result vector. The completed result is presented on a valid/ready output port.

Parameters:
ELEMENT_SIZE, 16, bits per element (passed to alu_element_vec)
NUM_ELEMENTS, 8, elements per vector
LANES, 2, alu_element_vec instances (elements processed per cycle); NUM_ELEMENTS % LANES == 0 is required (elaboration-time check)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  sequencer can accept an operation
in_opcode  input  3  opcode, forwarded unchanged to every lane
in_vec_a  input  NUM_ELEMENTS*ELEMENT_SIZE  operand A; element i at [i*ELEMENT_SIZE +: ELEMENT_SIZE]
in_vec_b  input  NUM_ELEMENTS*ELEMENT_SIZE  operand B; same packing
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_vec  output  NUM_ELEMENTS*ELEMENT_SIZE  result vector; same packing
busy  output  1  high in EXEC or DONE

Behaviour:
- Clocking and reset: one clock (clk). rst is asynchronous and active-high. On rst: state=IDLE, idx=0, out_vec=0, out_valid=0, busy=0. in_ready=1 once rst deasserts.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_opcode, in_vec_a and in_vec_b into internal registers; clear result register; idx=0; go to EXEC.
- EXEC:
  - in_ready=0.
  - Each cycle, lane l drives alu_element_vec with elements idx+l of latched A and B and the latched opcode.
  - At the clock edge, the lane result is written into result element idx+l; idx += LANES.
  - On the beat where idx+LANES == NUM_ELEMENTS, go to DONE.
- DONE:
  - out_valid=1; out_vec holds the full result and stays stable until handshake.
  - On out_ready, go to IDLE, drop out_valid, and keep out_vec at its last value.
- Latency: out_valid asserts exactly NUM_ELEMENTS/LANES cycles after the accept edge (4 with defaults).
- Throughput: one operation per NUM_ELEMENTS/LANES+2 cycles. No overlap of consecutive operations.
- Arithmetic: defined entirely by alu_element_vec. Results wrap modulo 2^ELEMENT_SIZE; no carry or overflow flags.
- Boundary conditions:
  - in_valid while busy: ignored, no latch (in_ready=0).
  - Input operands changing after accept: no effect.
  - out_ready held high before DONE: no effect.
  - out_ready low: DONE held indefinitely.
  - rst mid-EXEC or in DONE: immediate abort to reset values; no partial result is ever presented.
  - NUM_ELEMENTS==LANES: single EXEC beat.

Decomposition:
- Package vec_alu_pkg:
  - ELEMENT_SIZE_DEF=16, NUM_ELEMENTS_DEF=8, OPCODE_W=3
  - opcode constants (OP_ADD=3'b000, remaining codes as defined for alu_element_vec)
  - state enum seq_state_t {IDLE, EXEC, DONE}
- Sub-module: alu_element_vec, instantiated LANES times in a generate loop.
- Sequencer FSM, index counter and result register live in vec_alu_sequencer itself (est. 150–250 lines).

Test Plan:
1. Reset: hold rst 3 cycles, release -> in_ready=1, out_valid=0, out_vec=0, busy=0.
2. ADD basic: opcode 000, A={8,1,2,3,4,5,6,7}, B=all 5 -> out_vec={13,6,7,8,9,10,11,12}; out_valid asserts exactly 4 cycles after accept edge; busy high for those 4 cycles plus the DONE cycle(s).
3. Wrap: opcode 000, A=all 16'hFFFF, B=all 16'h0001 -> out_vec all 0; A element 3=16'h8000, B element 3=16'h8000 -> element 3=0.
4. Backpressure: complete op with out_ready=0 for 10 cycles, pulse in_valid with a second op meanwhile -> out_valid held, out_vec stable, in_ready=0, second op not accepted. Raise out_ready -> IDLE next cycle with in_ready=1; second op re-sent and its result is correct.
5. Reset mid-op: assert rst after 2 EXEC beats -> out_valid=0, out_vec=0, busy=0 immediately (asynchronous). A fresh op after release produces correct results with no residue from the aborted op.
6. Operand stability: change in_vec_a/in_vec_b every cycle during EXEC -> result matches operands latched at accept.
